// File: rtl/tblink_rpc_cmdout_arb_pkg.sv
// tblink_rpc_cmdout_arb_pkg: command codes, FSM encodings and grant-width helper
package tblink_rpc_cmdout_arb_pkg;

    localparam logic [7:0] CMD_OUT_TIMER_EXPIRE = 8'd1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    function automatic int gnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tblink_rpc_rr_arb.sv
// tblink_rpc_rr_arb: combinational round-robin pick starting just after last_grant
module tblink_rpc_rr_arb
    import tblink_rpc_cmdout_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    localparam int GW = gnt_w(N_REQ)
) (
    input  logic [N_REQ-1:0] pending,
    input  logic [GW-1:0]    last_grant,
    output logic [GW-1:0]    gnt_idx,
    output logic             gnt_valid
);

    logic [GW-1:0] idx;

    // Walk from furthest to nearest so the nearest pending index after last_grant wins
    always_comb begin
        gnt_idx = '0;
        gnt_valid = 1'b0;
        idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = GW'((int'(last_grant) + k) % N_REQ);
            if (pending[idx]) begin
                gnt_idx = idx;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tblink_rpc_cmdout_arb.sv
// tblink_rpc_cmdout_arb: round-robin sharing of the cmdproc outbound command channel
module tblink_rpc_cmdout_arb
    import tblink_rpc_cmdout_arb_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int PARAMS_SZ = 1,
    parameter int RSP_SZ    = 1
) (
    input  logic                           uclock,
    input  logic                           reset,
    input  logic [N_REQ-1:0]               req_put_i,
    output logic [N_REQ-1:0]               req_get_i,
    input  logic [8*N_REQ-1:0]             req_cmd,
    input  logic [8*N_REQ-1:0]             req_sz,
    input  logic [8*PARAMS_SZ*N_REQ-1:0]   req_params,
    output logic [8*RSP_SZ-1:0]            req_rsp,
    output logic [7:0]                     req_rsp_sz,
    output logic [7:0]                     cmd_out,
    output logic [7:0]                     cmd_out_sz,
    output logic [8*PARAMS_SZ-1:0]         cmd_out_params,
    output logic                           cmd_out_put_i,
    input  logic                           cmd_out_get_i,
    input  logic [8*RSP_SZ-1:0]            cmd_out_rsp,
    input  logic [7:0]                     cmd_out_rsp_sz,
    output logic                           busy
);

    localparam int GW = gnt_w(N_REQ);

    logic [0:0]             state;
    logic [GW-1:0]          last_grant;
    logic [GW-1:0]          grant_r;
    logic [GW-1:0]          gnt_idx;
    logic                   gnt_valid;
    logic [N_REQ-1:0]       pending;
    logic [7:0]             sel_cmd;
    logic [7:0]             sel_sz;
    logic [8*PARAMS_SZ-1:0] sel_params;

    assign pending = req_put_i ^ req_get_i;
    assign busy = state == WAIT;

    tblink_rpc_rr_arb #(.N_REQ(N_REQ)) u_rr (
        .pending    (pending),
        .last_grant (last_grant),
        .gnt_idx    (gnt_idx),
        .gnt_valid  (gnt_valid)
    );

    // Mux the granted requester's command fields
    always_comb begin
        sel_cmd = '0;
        sel_sz = '0;
        sel_params = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == GW'(i)) begin
                sel_cmd = req_cmd[8*i +: 8];
                sel_sz = req_sz[8*i +: 8];
                sel_params = req_params[8*PARAMS_SZ*i +: 8*PARAMS_SZ];
            end
        end
    end

    // Issue in IDLE, collect the response in WAIT; a completion seen in IDLE is ignored
    always_ff @(posedge uclock) begin
        if (reset) begin
            state <= IDLE;
            last_grant <= GW'(N_REQ - 1);
            grant_r <= '0;
            req_get_i <= '0;
            req_rsp <= '0;
            req_rsp_sz <= '0;
            cmd_out <= '0;
            cmd_out_sz <= '0;
            cmd_out_params <= '0;
            cmd_out_put_i <= 1'b0;
        end else if (state == IDLE && gnt_valid) begin
            cmd_out <= sel_cmd;
            cmd_out_sz <= sel_sz;
            cmd_out_params <= sel_params;
            cmd_out_put_i <= ~cmd_out_put_i;
            grant_r <= gnt_idx;
            state <= WAIT;
        end else if (state == WAIT && cmd_out_put_i == cmd_out_get_i) begin
            req_rsp <= cmd_out_rsp;
            req_rsp_sz <= cmd_out_rsp_sz;
            req_get_i <= req_get_i ^ (N_REQ'(1) << grant_r);
            last_grant <= grant_r;
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_tblink_rpc_cmdout_arb.sv
// tb_tblink_rpc_cmdout_arb: directed checks of the command-out arbiter (2- and 4-requester instances)
module tb_tblink_rpc_cmdout_arb;

    logic uclock = 1'b0;
    logic reset = 1'b1;
    always #5 uclock = ~uclock;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [1:0]  a_put, a_get;
    logic [15:0] a_cmd, a_sz, a_params;
    logic [7:0]  a_rsp, a_rsp_sz, a_co, a_co_sz, a_co_params, a_co_rsp, a_co_rsp_sz;
    logic        a_co_put, a_co_get, a_busy;
    int          a_dly, a_cnt;

    logic [3:0]  b_put, b_get;
    logic [31:0] b_cmd, b_sz, b_params;
    logic [7:0]  b_rsp, b_rsp_sz, b_co, b_co_sz, b_co_params, b_co_rsp, b_co_rsp_sz;
    logic        b_co_put, b_co_get, b_busy;
    int          b_dly, b_cnt;

    logic [7:0] a_log[$];
    int         a_log_cyc[$];
    logic [7:0] b_log[$];
    logic       a_put_seen, b_put_seen;
    logic [1:0] a_get_seen;
    int         a_done = 0;

    tblink_rpc_cmdout_arb #(.N_REQ(2), .PARAMS_SZ(1), .RSP_SZ(1)) dut_a (
        .uclock(uclock), .reset(reset),
        .req_put_i(a_put), .req_get_i(a_get),
        .req_cmd(a_cmd), .req_sz(a_sz), .req_params(a_params),
        .req_rsp(a_rsp), .req_rsp_sz(a_rsp_sz),
        .cmd_out(a_co), .cmd_out_sz(a_co_sz), .cmd_out_params(a_co_params),
        .cmd_out_put_i(a_co_put), .cmd_out_get_i(a_co_get),
        .cmd_out_rsp(a_co_rsp), .cmd_out_rsp_sz(a_co_rsp_sz),
        .busy(a_busy)
    );

    tblink_rpc_cmdout_arb #(.N_REQ(4), .PARAMS_SZ(1), .RSP_SZ(1)) dut_b (
        .uclock(uclock), .reset(reset),
        .req_put_i(b_put), .req_get_i(b_get),
        .req_cmd(b_cmd), .req_sz(b_sz), .req_params(b_params),
        .req_rsp(b_rsp), .req_rsp_sz(b_rsp_sz),
        .cmd_out(b_co), .cmd_out_sz(b_co_sz), .cmd_out_params(b_co_params),
        .cmd_out_put_i(b_co_put), .cmd_out_get_i(b_co_get),
        .cmd_out_rsp(b_co_rsp), .cmd_out_rsp_sz(b_co_rsp_sz),
        .busy(b_busy)
    );

    // cmdproc model: response is a fixed function of the command byte
    assign a_co_rsp = a_co ^ 8'h3D;
    assign a_co_rsp_sz = 8'd1;
    assign b_co_rsp = b_co ^ 8'h3D;
    assign b_co_rsp_sz = 8'd1;

    always @(posedge uclock) cyc <= cyc + 1;

    // cmdproc model: acknowledge a pending command after a programmable delay
    always @(posedge uclock) begin
        if (reset) begin
            a_co_get <= 1'b0;
            a_cnt <= 0;
            b_co_get <= 1'b0;
            b_cnt <= 0;
        end else begin
            if (a_co_put != a_co_get) begin
                if (a_cnt >= a_dly) begin
                    a_co_get <= a_co_put;
                    a_cnt <= 0;
                end else a_cnt <= a_cnt + 1;
            end
            if (b_co_put != b_co_get) begin
                if (b_cnt >= b_dly) begin
                    b_co_get <= b_co_put;
                    b_cnt <= 0;
                end else b_cnt <= b_cnt + 1;
            end
        end
    end

    // Monitor: log every issued command and count requester acks
    always @(negedge uclock) begin
        if (reset) begin
            a_put_seen <= 1'b0;
            b_put_seen <= 1'b0;
            a_get_seen <= '0;
        end else begin
            if (a_co_put != a_put_seen) begin
                a_log.push_back(a_co);
                a_log_cyc.push_back(cyc);
            end
            if (b_co_put != b_put_seen) b_log.push_back(b_co);
            a_put_seen <= a_co_put;
            b_put_seen <= b_co_put;
            a_done <= a_done + $countones(a_get ^ a_get_seen);
            a_get_seen <= a_get;
        end
    end

    task automatic step;
        @(negedge uclock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        a_put = '0;
        b_put = '0;
        step;
        step;
        reset = 1'b0;
    endtask

    task automatic wait_a_idle(input int lim, output bit ok);
        int k = 0;
        while ((a_put != a_get || a_busy) && k < lim) begin
            step;
            k++;
        end
        ok = (a_put == a_get) && !a_busy;
    endtask

    task automatic test_reset;
        a_put = '0; a_cmd = '0; a_sz = '0; a_params = '0; a_dly = 0;
        b_put = '0; b_cmd = '0; b_sz = '0; b_params = '0; b_dly = 0;
        do_reset;
        reset = 1'b1;
        step;
        n_checks++;
        if ({a_get, a_rsp, a_rsp_sz, a_co, a_co_sz, a_co_params, a_co_put, a_busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_a: got get=%b rsp=%h co=%h put=%b busy=%b, want all 0", a_get, a_rsp, a_co, a_co_put, a_busy);
        end
        n_checks++;
        if ({b_get, b_rsp, b_rsp_sz, b_co, b_co_sz, b_co_params, b_co_put, b_busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_b: got get=%b rsp=%h co=%h put=%b busy=%b, want all 0", b_get, b_rsp, b_co, b_co_put, b_busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_single;
        int k;
        bit stable = 1'b1;
        a_dly = 4;
        a_cmd[7:0] = 8'h01;
        a_sz[7:0] = 8'd1;
        a_params[7:0] = 8'hA5;
        a_put[0] = ~a_put[0];
        step;
        n_checks++;
        if ({a_co, a_co_params, a_co_sz, a_co_put, a_busy} !== {8'h01, 8'hA5, 8'd1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL single_issue: got co=%h par=%h sz=%h put=%b busy=%b, want 01 a5 01 1 1", a_co, a_co_params, a_co_sz, a_co_put, a_busy);
        end
        k = 1;
        while (a_get[0] != a_put[0] && k < 40) begin
            step;
            k++;
            if (a_get[0] != a_put[0] && (a_co !== 8'h01 || a_co_params !== 8'hA5)) stable = 1'b0;
        end
        n_checks++;
        if (k !== 7 || !stable) begin
            n_fail++;
            $display("FAIL single_latency: got %0d cycles stable=%b, want 7 cycles stable=1", k, stable);
        end
        n_checks++;
        if ({a_rsp, a_rsp_sz, a_busy} !== {8'h3C, 8'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_rsp: got rsp=%h sz=%h busy=%b, want 3c 01 0", a_rsp, a_rsp_sz, a_busy);
        end
    endtask

    task automatic test_simultaneous;
        bit ok;
        do_reset;
        a_dly = 2;
        a_cmd = {8'h22, 8'h11};
        a_params = {8'hB2, 8'hB1};
        a_log.delete();
        a_log_cyc.delete();
        a_put = ~a_put;
        wait_a_idle(60, ok);
        n_checks++;
        if (!ok || a_log.size() != 2 || a_log[0] !== 8'h11 || a_log[1] !== 8'h22) begin
            n_fail++;
            $display("FAIL simul_order: got ok=%b n=%0d first=%h second=%h, want 11 then 22", ok, a_log.size(), a_log[0], a_log[1]);
        end
        n_checks++;
        if (a_log_cyc.size() != 2 || a_log_cyc[1] - a_log_cyc[0] != 5) begin
            n_fail++;
            $display("FAIL simul_gap: got issue spacing %0d, want 5", a_log_cyc.size() == 2 ? a_log_cyc[1] - a_log_cyc[0] : -1);
        end
        a_put[0] = ~a_put[0];
        wait_a_idle(60, ok);
        a_log.delete();
        a_put = ~a_put;
        wait_a_idle(60, ok);
        n_checks++;
        if (!ok || a_log.size() != 2 || a_log[0] !== 8'h22 || a_log[1] !== 8'h11) begin
            n_fail++;
            $display("FAIL simul_rotate: got ok=%b n=%0d first=%h second=%h, want 22 then 11", ok, a_log.size(), a_log[0], a_log[1]);
        end
    endtask

    task automatic test_rr4;
        int k = 0;
        logic [7:0] got, exp;
        b_dly = 0;
        b_cmd = {8'h43, 8'h42, 8'h41, 8'h40};
        b_log.delete();
        while (b_log.size() < 12 && k < 300) begin
            for (int i = 0; i < 4; i++) if (b_put[i] == b_get[i]) b_put[i] = ~b_put[i];
            step;
            k++;
        end
        k = 0;
        while ((b_put != b_get || b_busy) && k < 100) begin
            step;
            k++;
        end
        for (int j = 0; j < 12; j++) begin
            got = j < b_log.size() ? b_log[j] : 8'hXX;
            exp = 8'h40 + 8'(j % 4);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL rr4_grant%0d: got %h, want %h", j, got, exp);
            end
        end
    endtask

    task automatic test_wait_queue;
        bit ok;
        bit stable = 1'b1;
        int k = 0;
        a_dly = 19;
        a_log.delete();
        a_cmd[7:0] = 8'h55;
        a_sz[7:0] = 8'd2;
        a_params[7:0] = 8'h66;
        a_put[0] = ~a_put[0];
        step;
        step;
        a_cmd[15:8] = 8'h77;
        a_params[15:8] = 8'h88;
        a_put[1] = ~a_put[1];
        while (a_get[0] != a_put[0] && k < 60) begin
            if ({a_co, a_co_params, a_co_sz, a_busy} !== {8'h55, 8'h66, 8'd2, 1'b1}) stable = 1'b0;
            step;
            k++;
        end
        n_checks++;
        if (!stable || a_get[0] != a_put[0] || a_rsp !== 8'h68) begin
            n_fail++;
            $display("FAIL wait_stable: got stable=%b rsp=%h, want stable=1 rsp=68", stable, a_rsp);
        end
        wait_a_idle(80, ok);
        n_checks++;
        if (!ok || a_log.size() != 2 || a_log[0] !== 8'h55 || a_log[1] !== 8'h77 || a_rsp !== 8'h4A || a_co_params !== 8'h88) begin
            n_fail++;
            $display("FAIL wait_queued: got ok=%b n=%0d second=%h rsp=%h par=%h, want 55,77 rsp=4a par=88", ok, a_log.size(), a_log[1], a_rsp, a_co_params);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        a_dly = 10;
        a_cmd[7:0] = 8'h01;
        a_put[0] = ~a_put[0];
        step;
        step;
        step;
        step;
        reset = 1'b1;
        a_put = '0;
        b_put = '0;
        step;
        n_checks++;
        if ({a_get, a_co, a_co_sz, a_co_params, a_co_put, a_busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got get=%b co=%h put=%b busy=%b, want all 0", a_get, a_co, a_co_put, a_busy);
        end
        reset = 1'b0;
        a_dly = 1;
        a_cmd[7:0] = 8'h5A;
        a_put[0] = 1'b1;
        wait_a_idle(40, ok);
        n_checks++;
        if (!ok || a_get !== 2'b01 || a_rsp !== 8'h67) begin
            n_fail++;
            $display("FAIL reset_recover: got ok=%b get=%b rsp=%h, want get=01 rsp=67", ok, a_get, a_rsp);
        end
    endtask

    task automatic test_zero_wait;
        int k;
        int done0;
        a_dly = 0;
        a_log.delete();
        done0 = a_done;
        for (int j = 0; j < 3; j++) begin
            a_cmd[7:0] = 8'h30 + 8'(j);
            a_put[0] = ~a_put[0];
            k = 0;
            do begin
                step;
                k++;
            end while (a_get[0] != a_put[0] && k < 20);
            n_checks++;
            if (k !== 3 || a_rsp !== ((8'h30 + 8'(j)) ^ 8'h3D)) begin
                n_fail++;
                $display("FAIL zero_wait%0d: got %0d cycles rsp=%h, want 3 cycles rsp=%h", j, k, a_rsp, (8'h30 + 8'(j)) ^ 8'h3D);
            end
        end
        for (int j = 0; j < 5; j++) step;
        n_checks++;
        if (a_done - done0 != 3 || a_log.size() != 3 || a_busy) begin
            n_fail++;
            $display("FAIL zero_wait_once: got acks=%0d issues=%0d busy=%b, want 3 3 0", a_done - done0, a_log.size(), a_busy);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_simultaneous;
        test_rr4;
        test_wait_queue;
        test_reset_mid;
        test_zero_wait;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
